// File: rtl/ssd_scan_mux.sv
// Time-multiplexed 7-segment scan driver with shadow/active double buffering.
// Optional leading-zero blanking is enabled by defining SSD_LZ_BLANK_EN.
module ssd_scan_mux #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic                    load,
  input  logic                    en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DAT_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DAT_W-1:0]      shadow_q, shadow_d;
  logic [DAT_W-1:0]      active_q, active_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  tick_q, tick_d;

  logic       wrap_c, last_c, frame_end_c, blank_c;
  logic [3:0] nib_c;

  // Standard active-low hex decode, bit order seg[6:0] = g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Scan sequencing, buffer transfer and output decode.
  always_comb begin
    wrap_c      = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    last_c      = (idx_q == IDX_W'(NUM_DIGITS - 1));
    frame_end_c = wrap_c && last_c;

    cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (wrap_c) begin
      idx_d = last_c ? '0 : idx_q + IDX_W'(1);
    end

    shadow_d = load ? din : shadow_q;
    // Frame-boundary transfer uses the pre-load shadow, so a coincident load waits a frame.
    active_d = frame_end_c ? shadow_q : active_q;
    tick_d   = frame_end_c;

    nib_c   = '0;
    blank_c = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_c = active_q[4*k +: 4];
`ifdef SSD_LZ_BLANK_EN
        blank_c = (k != 0) && ((active_q >> (4*k)) == '0);
`endif
      end
    end

    an_d  = en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d = (en && !blank_c) ? hex_to_seg(nib_c) : 7'h7F;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      seg_q    <= 7'h7F;
      an_q     <= '1;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Directed + random bench for ssd_scan_mux (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_ssd_scan_mux;

  localparam int unsigned ND  = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned FRM = ND * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] din = '0;
  logic        load = 1'b0;
  logic        en = 1'b1;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;
  int n = 0;
  int ft_seen = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_active = '0;

  ssd_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .din(din), .load(load), .en(en),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] lut [16];
    lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return lut[v];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // One clock: derive expectations from elapsed cycles since reset, then compare.
  task automatic tick();
    logic [3:0] e_an, nib;
    logic [6:0] e_seg;
    logic       e_ft, blank;
    int d;
    if (reset) begin
      e_an = 4'hF; e_seg = 7'h7F; e_ft = 1'b0;
    end else begin
      d     = (n / DIV) % ND;
      nib   = m_active[d*4 +: 4];
      blank = 1'b0;
`ifdef SSD_LZ_BLANK_EN
      blank = (d != 0) && ((m_active >> (4*d)) == 16'h0);
`endif
      e_an  = en ? ~(4'b0001 << d) : 4'hF;
      e_seg = (en && !blank) ? hex7(nib) : 7'h7F;
      e_ft  = ((n % FRM) == FRM - 1);
    end
    @(posedge clk);
    if (reset) begin
      n = 0; m_shadow = '0; m_active = '0;
    end else begin
      if ((n % FRM) == FRM - 1) m_active = m_shadow;
      if (load) m_shadow = din;
      n++;
    end
    #1;
    if (frame_tick === 1'b1) ft_seen++;
    chk("an", 16'(an), 16'(e_an));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("frame_tick", 16'(frame_tick), 16'(e_ft));
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    reset = 1'b0;

    // Idle frame: all zeros, one frame_tick at cycle 16
    ft_seen = 0;
    repeat (16) tick();
    chk("ft_count_frame0", 16'(ft_seen), 16'd1);

    // Mid-frame load
    repeat (5) tick();
    din = 16'hFA81; load = 1'b1; tick(); load = 1'b0;
    repeat (40) tick();

    // Load coinciding with frame boundary
    while ((n % FRM) != FRM - 1) tick();
    din = 16'h5A3C; load = 1'b1; tick(); load = 1'b0;
    repeat (36) tick();

    // Display disabled for one whole frame
    while ((n % FRM) != 0) tick();
    ft_seen = 0;
    en = 1'b0;
    repeat (16) tick();
    en = 1'b1;
    chk("ft_count_en_off", 16'(ft_seen), 16'd1);

    // Leading-zero behaviour
    din = 16'h0005; load = 1'b1; tick(); load = 1'b0;
    repeat (40) tick();

    // Reset during digit 2 with 1234 displayed
    din = 16'h1234; load = 1'b1; tick(); load = 1'b0;
    repeat (20) tick();
    while ((n % FRM) != 9) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    chk("post_reset_an", 16'(an), 16'h000E);
    chk("post_reset_seg", 16'(seg), 16'h0040);
    repeat (20) tick();

    // Randomised traffic
    repeat (400) begin
      reset = ($urandom % 80) == 0;
      load  = ($urandom % 6) == 0;
      din   = 16'($urandom);
      en    = ($urandom % 8) != 0;
      tick();
    end
    reset = 1'b0; load = 1'b0; en = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
